// File: rtl/coredma_dsc_cache_pkg.sv
// Shared constants for the CoreDMA descriptor-cache arbiter.
// Provides the default cache geometry, the address width derived from it,
// the RAM read pipeline depth, and a round-robin wrap helper.
package coredma_dsc_cache_pkg;

  localparam int unsigned DSC_WIDTH    = 128;
  localparam int unsigned DSC_DEPTH    = 128;
  localparam int unsigned DSC_AW       = $clog2(DSC_DEPTH);
  // Address register + data register inside the RAM wrapper.
  localparam int unsigned READ_LATENCY = 2;

  // Next round-robin position after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/coredma_rr_arbiter.sv
// Round-robin arbiter for the descriptor-cache read clients.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   req         per-client request vector
//   hold        suppress the grant this cycle and keep the pointer
//   gnt_c       one-hot grant (combinational)
//   gnt_idx_c   index of the current candidate (combinational)
//   any_c       at least one client is requesting (combinational)
//   ptr         registered round-robin pointer (search start)
module coredma_rr_arbiter
  import coredma_dsc_cache_pkg::*;
#(
  parameter  int unsigned NUM_RD = 4,
  localparam int unsigned IW     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RD-1:0] req,
  input  logic              hold,
  output logic [NUM_RD-1:0] gnt_c,
  output logic [IW-1:0]     gnt_idx_c,
  output logic              any_c,
  output logic [IW-1:0]     ptr
);

  logic          cand_found;
  logic [IW-1:0] cand_idx;
  int unsigned   j;

  // First requester at or after ptr, searching upward modulo NUM_RD.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    j          = 0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUM_RD) j = j - NUM_RD;
      if (!cand_found && req[IW'(j)]) begin
        cand_found = 1'b1;
        cand_idx   = IW'(j);
      end
    end
  end

  assign gnt_idx_c = cand_idx;
  assign any_c     = cand_found;
  assign gnt_c     = (cand_found && !hold) ? (NUM_RD'(1) << cand_idx) : '0;

  // Pointer advances past the winner only when a grant is actually issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (cand_found && !hold) begin
      ptr <= IW'(rr_next(32'(cand_idx), NUM_RD));
    end
  end

endmodule

// File: rtl/coredma_dsc_cache_arbiter.sv
// Shares the descriptor-cache RAM between the descriptor-fetch writer and
// NUM_RD channel read clients. Writes pass straight through; reads are
// round-robin arbitrated and returned READ_LATENCY cycles later with a
// one-hot owner tag.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_req/wr_addr/wr_data      write from descriptor fetch
//   rd_req/rd_addr              per-client read requests, packed addresses
//   rd_gnt                      one-hot grant (combinational)
//   rd_valid/rd_data            one-hot return tag and read data
//   ram_wen/ram_waddr/ram_wdata RAM write port
//   ram_ren/ram_raddr/ram_rdata RAM read port
module coredma_dsc_cache_arbiter
  import coredma_dsc_cache_pkg::*;
#(
  parameter  int unsigned WIDTH  = DSC_WIDTH,
  parameter  int unsigned DEPTH  = DSC_DEPTH,
  parameter  int unsigned NUM_RD = 4,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned IW     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NUM_RD-1:0]    rd_req,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_gnt,
  output logic [NUM_RD-1:0]    rd_valid,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 ram_wen,
  output logic [AW-1:0]        ram_waddr,
  output logic [WIDTH-1:0]     ram_wdata,
  output logic                 ram_ren,
  output logic [AW-1:0]        ram_raddr,
  input  logic [WIDTH-1:0]     ram_rdata
);

  logic [NUM_RD-1:0] gnt;
  logic [IW-1:0]     cand_idx;
  logic [IW-1:0]     rr_ptr;
  logic              cand_any;
  logic              collision;
  logic              arb_hold;
  logic              gnt_any;
  logic              tag_any;
  logic [AW-1:0]     cand_addr;
  logic [AW-1:0]     raddr_q;
  logic [NUM_RD-1:0] tag_q [READ_LATENCY];

  // Address of the current arbitration candidate.
  always_comb begin
    cand_addr = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (IW'(i) == cand_idx) cand_addr = rd_addr[i*AW +: AW];
    end
  end

  // A same-cycle write to the candidate's address defers the read one cycle
  // so it sees the new data. Reset also holds off grants.
  assign collision = wr_req & cand_any & (cand_addr == wr_addr);
  assign arb_hold  = collision | ~rst_n;

  coredma_rr_arbiter #(
    .NUM_RD (NUM_RD)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (rd_req),
    .hold      (arb_hold),
    .gnt_c     (gnt),
    .gnt_idx_c (cand_idx),
    .any_c     (cand_any),
    .ptr       (rr_ptr)
  );

  assign rd_gnt  = gnt;
  assign gnt_any = |gnt;

  // Read address follows the winner; otherwise keeps the last issued address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
    end else if (gnt_any) begin
      raddr_q <= cand_addr;
    end
  end

  assign ram_raddr = gnt_any ? cand_addr : raddr_q;

  // Owner tag pipe, aligned with the RAM address and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= gnt;
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // RAM stays enabled while any read is still travelling through it.
  always_comb begin
    tag_any = 1'b0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) tag_any = tag_any | (|tag_q[i]);
  end

  assign ram_ren   = gnt_any | tag_any;
  assign rd_valid  = tag_q[READ_LATENCY-1];
  assign rd_data   = ram_rdata;

  assign ram_wen   = wr_req & rst_n;
  assign ram_waddr = wr_addr;
  assign ram_wdata = wr_data;

  ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n) 32'(rr_ptr) < NUM_RD);

endmodule

// File: tb/tb_coredma_dsc_cache_arbiter.sv
// Bench for coredma_dsc_cache_arbiter: RAM model, reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_coredma_dsc_cache_arbiter;
  import coredma_dsc_cache_pkg::*;

  localparam int unsigned WIDTH  = DSC_WIDTH;
  localparam int unsigned DEPTH  = DSC_DEPTH;
  localparam int unsigned AW     = DSC_AW;
  localparam int unsigned NUM_RD = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wr_req;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [NUM_RD-1:0]    rd_req;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD-1:0]    rd_gnt;
  logic [NUM_RD-1:0]    rd_valid;
  logic [WIDTH-1:0]     rd_data;
  logic                 ram_wen;
  logic [AW-1:0]        ram_waddr;
  logic [WIDTH-1:0]     ram_wdata;
  logic                 ram_ren;
  logic [AW-1:0]        ram_raddr;
  logic [WIDTH-1:0]     ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  coredma_dsc_cache_arbiter #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  // RAM: one write port, read through address register then data register.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic [AW-1:0]    ram_addr_r;
  logic [WIDTH-1:0] ram_data_r;

  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
    if (ram_ren) begin
      ram_addr_r <= ram_raddr;
      ram_data_r <= ram_mem[ram_addr_r];
    end
  end
  assign ram_rdata = ram_data_r;

  function automatic logic [WIDTH-1:0] init_word(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(i);
    return {w, w, w, w};
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: memory contents, pointer, and a queue of reads in flight.
  typedef struct {
    int               due;
    int               owner;
    logic [WIDTH-1:0] data;
  } pend_t;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  pend_t            pend [$];
  int               m_ptr = 0;
  int               cyc   = 0;

  always @(negedge clk) begin : model
    logic [NUM_RD-1:0] e_gnt;
    logic [NUM_RD-1:0] e_val;
    logic [WIDTH-1:0]  e_data;
    logic              e_ren;
    logic [AW-1:0]     caddr;
    int                cand;
    e_gnt  = '0;
    e_val  = '0;
    e_data = '0;
    e_ren  = 1'b0;
    caddr  = '0;
    cand   = -1;
    if (!rst_n) begin
      m_ptr = 0;
      pend.delete();
      chk("m_rst_gnt", WIDTH'(rd_gnt), '0);
      chk("m_rst_valid", WIDTH'(rd_valid), '0);
      chk("m_rst_ren", WIDTH'(ram_ren), '0);
      chk("m_rst_wen", WIDTH'(ram_wen), '0);
    end else begin
      e_ren = (pend.size() != 0);
      if (pend.size() != 0 && pend[0].due == cyc) begin
        e_val[pend[0].owner] = 1'b1;
        e_data = pend[0].data;
        void'(pend.pop_front());
      end
      for (int k = 0; k < NUM_RD; k++) begin
        int jj;
        jj = (m_ptr + k) % NUM_RD;
        if (cand < 0 && rd_req[jj]) cand = jj;
      end
      if (cand >= 0) begin
        caddr = rd_addr[cand*AW +: AW];
        if (!(wr_req && caddr == wr_addr)) begin
          e_gnt[cand] = 1'b1;
          e_ren = 1'b1;
          pend.push_back('{due: cyc + 2, owner: cand, data: ref_mem[caddr]});
          m_ptr = (cand + 1) % NUM_RD;
          chk("m_raddr", WIDTH'(ram_raddr), WIDTH'(caddr));
        end
      end
      chk("m_gnt", WIDTH'(rd_gnt), WIDTH'(e_gnt));
      chk("m_valid", WIDTH'(rd_valid), WIDTH'(e_val));
      chk("m_ren", WIDTH'(ram_ren), WIDTH'(e_ren));
      chk("m_wen", WIDTH'(ram_wen), WIDTH'(wr_req));
      if (wr_req) begin
        chk("m_waddr", WIDTH'(ram_waddr), WIDTH'(wr_addr));
        chk("m_wdata", ram_wdata, wr_data);
        ref_mem[wr_addr] = wr_data;
      end
      if (e_val != '0) chk("m_rdata", rd_data, e_data);
    end
    cyc++;
  end

  logic [NUM_RD-1:0] exp_oh;
  logic [WIDTH-1:0]  new9;
  logic [WIDTH-1:0]  new10;
  logic [WIDTH-1:0]  new11;
  logic [WIDTH-1:0]  pat_a5;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    new9   = {4{32'h9999_0009}};
    new10  = {4{32'h1010_1010}};
    new11  = {4{32'h1111_1111}};
    pat_a5 = {16{8'hA5}};

    // 1: reset held with everything requesting and a write pending.
    rst_n   = 1'b0;
    wr_req  = 1'b1;
    wr_addr = AW'(100);
    wr_data = '1;
    rd_req  = 4'b1111;
    for (int i = 0; i < NUM_RD; i++) rd_addr[i*AW +: AW] = AW'(i);
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", WIDTH'(rd_gnt), '0);
      chk("rst_valid", WIDTH'(rd_valid), '0);
      chk("rst_wen", WIDTH'(ram_wen), '0);
      next_cycle();
    end
    rst_n  = 1'b1;
    wr_req = 1'b0;
    @(negedge clk);
    chk("rel_first_gnt", WIDTH'(rd_gnt), WIDTH'(4'b0001));
    next_cycle();
    rd_req = '0;
    repeat (3) next_cycle();

    // 2: write addr 5, client 2 reads it the next cycle.
    wr_req  = 1'b1;
    wr_addr = AW'(5);
    wr_data = pat_a5;
    @(negedge clk);
    next_cycle();
    wr_req = 1'b0;
    rd_req = 4'b0100;
    rd_addr[2*AW +: AW] = AW'(5);
    @(negedge clk);
    chk("t2_gnt", WIDTH'(rd_gnt), WIDTH'(4'b0100));
    next_cycle();
    rd_req = '0;
    next_cycle();
    @(negedge clk);
    chk("t2_valid", WIDTH'(rd_valid), WIDTH'(4'b0100));
    chk("t2_data", rd_data, pat_a5);
    next_cycle();
    repeat (2) next_cycle();

    // 3: reset the pointer, then all four request continuously.
    rst_n = 1'b0;
    next_cycle();
    rst_n  = 1'b1;
    rd_req = 4'b1111;
    for (int i = 0; i < NUM_RD; i++) rd_addr[i*AW +: AW] = AW'(i);
    for (int k = 0; k < 7; k++) begin
      if (k == 5) rd_req = '0;
      @(negedge clk);
      if (k < 5) begin
        exp_oh = NUM_RD'(1 << (k % 4));
        chk("t3_gnt", WIDTH'(rd_gnt), WIDTH'(exp_oh));
      end
      if (k >= 2) begin
        exp_oh = NUM_RD'(1 << ((k - 2) % 4));
        chk("t3_valid", WIDTH'(rd_valid), WIDTH'(exp_oh));
        chk("t3_data", rd_data, init_word((k - 2) % 4));
      end
      next_cycle();
    end

    // 4: collision on addr 9 with client 1 as candidate.
    rd_req = 4'b0010;
    rd_addr[1*AW +: AW] = AW'(9);
    wr_req  = 1'b1;
    wr_addr = AW'(9);
    wr_data = new9;
    @(negedge clk);
    chk("t4_coll_gnt", WIDTH'(rd_gnt), '0);
    next_cycle();
    wr_req = 1'b0;
    @(negedge clk);
    chk("t4_retry_gnt", WIDTH'(rd_gnt), WIDTH'(4'b0010));
    next_cycle();
    rd_req = '0;
    next_cycle();
    @(negedge clk);
    chk("t4_valid", WIDTH'(rd_valid), WIDTH'(4'b0010));
    chk("t4_data", rd_data, new9);
    next_cycle();

    // Non-colliding write: grant is immediate; a write one cycle later
    // to the granted address is not seen by that read.
    rd_req = 4'b0100;
    rd_addr[2*AW +: AW] = AW'(10);
    wr_req  = 1'b1;
    wr_addr = AW'(11);
    wr_data = new11;
    @(negedge clk);
    chk("t4_nocoll_gnt", WIDTH'(rd_gnt), WIDTH'(4'b0100));
    next_cycle();
    rd_req  = '0;
    wr_addr = AW'(10);
    wr_data = new10;
    next_cycle();
    wr_req = 1'b0;
    @(negedge clk);
    chk("t4_prewrite_valid", WIDTH'(rd_valid), WIDTH'(4'b0100));
    chk("t4_prewrite_data", rd_data, init_word(10));
    next_cycle();

    // 5: reset while client 3's read is in flight.
    rd_req = 4'b1000;
    rd_addr[3*AW +: AW] = AW'(7);
    @(negedge clk);
    chk("t5_gnt", WIDTH'(rd_gnt), WIDTH'(4'b1000));
    next_cycle();
    rd_req = '0;
    rst_n  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_valid", WIDTH'(rd_valid), '0);
      next_cycle();
    end
    rd_req = 4'b1111;
    for (int i = 0; i < NUM_RD; i++) rd_addr[i*AW +: AW] = AW'(i);
    @(negedge clk);
    chk("t5_ptr0_gnt", WIDTH'(rd_gnt), WIDTH'(4'b0001));
    next_cycle();
    rd_req = '0;
    repeat (3) next_cycle();

    // 6: only client 3 requests, every cycle, with writes elsewhere.
    rd_req = 4'b1000;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 24; k++) begin
        if (ph == 0) begin
          rd_addr[3*AW +: AW] = AW'((k * 7) % 64);
          wr_addr = AW'(64 + (k * 5) % 64);
        end else begin
          rd_addr[3*AW +: AW] = AW'(64 + (k * 5) % 64);
          wr_addr = AW'((k * 11) % 64);
        end
        wr_req  = ((k % 3) == 0);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("t6_gnt", WIDTH'(rd_gnt), WIDTH'(4'b1000));
        next_cycle();
      end
    end
    rd_req = '0;
    wr_req = 1'b0;
    repeat (4) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
